// File: rtl/fetch_queue_if.sv
// Bus bundle for the fetch queue: icache request/response, decode output,
// redirect inputs and debug visibility of the request FSM.
//
// Handshake: addr_ready is a one-cycle request strobe that qualifies addr.
// cache_ack is a one-cycle response strobe that qualifies inst. Each request
// receives exactly one ack, and neither side can apply backpressure. At most
// one request is outstanding at any time.
interface fetch_queue_if #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic            cache_ack;
    logic [XLEN-1:0] inst;
    logic            addr_ready;
    logic [XLEN-1:0] addr;
    logic            stall;
    logic            jal;
    logic            branch;
    logic [XLEN-1:0] j_target;
    logic [XLEN-1:0] b_target;
    logic [XLEN-1:0] final_pc;
    logic [XLEN-1:0] final_inst;
    logic [CW-1:0]   q_count;
    logic [1:0]      fsm_state;   // {drop, request state}

    // Fetch queue side
    modport master (
        input  cache_ack, inst, stall, jal, branch, j_target, b_target,
        output addr_ready, addr, final_pc, final_inst, q_count, fsm_state
    );

    // Environment side (icache + decode)
    modport slave (
        output cache_ack, inst, stall, jal, branch, j_target, b_target,
        input  addr_ready, addr, final_pc, final_inst, q_count, fsm_state
    );
endinterface

// File: rtl/fetch_queue.sv
// Fetch queue: keeps one icache request in flight, buffers returned
// instructions in a DEPTH-entry queue and presents them to decode.
// jal/branch redirects flush the queue and drop any in-flight response.
module fetch_queue #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter logic [XLEN-1:0] NOP      = 32'h0000_0013
) (
    input  logic          clk,
    input  logic          rst,
    fetch_queue_if.master bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] WAIT = 1'b1;

    logic [0:0]      state;
    logic            drop;
    logic [XLEN-1:0] fetch_pc;
    logic            req;
    logic [XLEN-1:0] req_addr;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_inst;

    logic [XLEN-1:0] pc_mem   [DEPTH];
    logic [XLEN-1:0] inst_mem [DEPTH];
    logic [AW-1:0]   head;
    logic [AW-1:0]   tail;
    logic [CW-1:0]   count;

    logic            redirect;
    logic            push;
    logic            pop;
    logic            can_issue;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] next_pc;
    logic [CW-1:0]   count_next;

    // Hazard decode and queue bookkeeping for the current cycle
    always_comb begin
        redirect   = bus.jal | bus.branch;
        target     = (bus.jal ? bus.j_target : bus.b_target) & ~XLEN'(3);
        push       = (state == WAIT) && bus.cache_ack && !drop && !redirect;
        pop        = !redirect && !bus.stall && (count != '0);
        count_next = count + CW'(push) - CW'(pop);
        // A new request reserves its slot up front, so its ack always fits
        can_issue  = count_next < CW'(DEPTH);
        next_pc    = fetch_pc + XLEN'(4);
    end

    // Queue storage: capture the address of the answered request and its instruction
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[tail]   <= req_addr;
            inst_mem[tail] <= bus.inst;
        end
    end

    // Request FSM, queue pointers and decode-side output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            drop     <= 1'b0;
            fetch_pc <= RESET_PC;
            req      <= 1'b0;
            req_addr <= '0;
            out_pc   <= '0;
            out_inst <= NOP;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
        end else begin
            req <= 1'b0;
            if (redirect) begin
                head     <= '0;
                tail     <= '0;
                count    <= '0;
                fetch_pc <= target;
                out_pc   <= '0;
                out_inst <= NOP;
                if (state == WAIT) begin
                    if (bus.cache_ack) begin
                        // Response lands on the redirect edge: discard it here
                        state <= IDLE;
                        drop  <= 1'b0;
                    end else begin
                        // Response still in flight: discard it when it arrives
                        drop <= 1'b1;
                    end
                end
            end else begin
                if (push) begin
                    tail <= tail + AW'(1);
                end
                if (pop) begin
                    head     <= head + AW'(1);
                    out_pc   <= pc_mem[head];
                    out_inst <= inst_mem[head];
                end else if (!bus.stall) begin
                    out_pc   <= '0;
                    out_inst <= NOP;
                end
                count <= count_next;

                case (state)
                    IDLE: begin
                        if (can_issue) begin
                            req      <= 1'b1;
                            req_addr <= fetch_pc;
                            state    <= WAIT;
                        end
                    end
                    default: begin
                        if (bus.cache_ack) begin
                            if (drop) begin
                                drop  <= 1'b0;
                                state <= IDLE;
                            end else begin
                                fetch_pc <= next_pc;
                                // Back-to-back issue straight from the ack edge
                                if (can_issue) begin
                                    req      <= 1'b1;
                                    req_addr <= next_pc;
                                end else begin
                                    state <= IDLE;
                                end
                            end
                        end
                    end
                endcase
            end
        end
    end

    assign bus.addr_ready = req;
    assign bus.addr       = req_addr;
    assign bus.final_pc   = out_pc;
    assign bus.final_inst = out_inst;
    assign bus.q_count    = count;
    assign bus.fsm_state  = {drop, state};

    // The icache must only answer while a request is outstanding
    ack_only_when_waiting: assert property (
        @(posedge clk) disable iff (!rst) !(bus.cache_ack && (state == IDLE))
    );
endmodule
